// File: rtl/alu_out_pipe.sv
// rtl/alu_out_pipe.sv - DEPTH-stage elastic valid/ready pipe for ALU result, carry and zero/neg flags
// Optional macro ALU_OUT_STICKY_CARRY_EN enables the cout_sticky register.
module alu_out_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_f_in,
    input  logic             alu_cout_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic [OCC_W-1:0] occupancy,
    output logic             cout_sticky
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_f [DEPTH];
    logic [DEPTH-1:0] r_cout;
    logic [DEPTH-1:0] r_zero;
    logic [DEPTH-1:0] r_neg;

    logic [DEPTH-1:0] w_adv;
    logic             w_in_xfer;
    logic [OCC_W-1:0] w_occ;

    // A stage may advance when any stage at or after it is empty, or the consumer takes the last one.
    always_comb begin : p_adv
        logic v_acc;
        w_adv = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_acc = out_ready;
            for (int j = k; j < DEPTH; j++) begin
                v_acc = v_acc | ~r_valid[j];
            end
            w_adv[k] = v_acc;
        end
    end

    assign in_ready  = w_adv[0] & ~flush & ~reset;
    assign w_in_xfer = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_cout  <= '0;
            r_zero  <= '0;
            r_neg   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_f[k] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    r_f[k]     <= r_f[k-1];
                    r_cout[k]  <= r_cout[k-1];
                    r_zero[k]  <= r_zero[k-1];
                    r_neg[k]   <= r_neg[k-1];
                end
            end
            if (w_adv[0]) begin
                r_valid[0] <= in_valid;
            end
            if (w_in_xfer) begin
                r_f[0]    <= alu_f_in;
                r_cout[0] <= alu_cout_in;
                r_zero[0] <= (alu_f_in == '0);
                r_neg[0]  <= alu_f_in[WIDTH-1];
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ = w_occ + OCC_W'(r_valid[k]);
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign f         = r_f[DEPTH-1];
    assign cout      = r_cout[DEPTH-1];
    assign zero      = r_zero[DEPTH-1];
    assign neg       = r_neg[DEPTH-1];
    assign occupancy = w_occ;

`ifdef ALU_OUT_STICKY_CARRY_EN
    logic r_cout_sticky;
    logic w_out_xfer;

    assign w_out_xfer = r_valid[DEPTH-1] & out_ready;

    // Flush wins over a same-cycle set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cout_sticky <= 1'b0;
        end else if (flush) begin
            r_cout_sticky <= 1'b0;
        end else if (w_out_xfer && r_cout[DEPTH-1]) begin
            r_cout_sticky <= 1'b1;
        end
    end

    assign cout_sticky = r_cout_sticky;
`else
    assign cout_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_out_pipe.sv
// tb/tb_alu_out_pipe.sv - self-checking bench for alu_out_pipe (vector table, corner sequences, random vs queue model)
module tb_alu_out_pipe;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int OCC_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_f_in;
    logic             alu_cout_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             zero;
    logic             neg;
    logic [OCC_W-1:0] occupancy;
    logic             cout_sticky;

    int checks   = 0;
    int failures = 0;

    alu_out_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_f_in   (alu_f_in),
        .alu_cout_in(alu_cout_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .f          (f),
        .cout       (cout),
        .zero       (zero),
        .neg        (neg),
        .occupancy  (occupancy),
        .cout_sticky(cout_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] fin;
        logic       cin;
        logic       ordy;
        logic       fl;
        logic       ir;
        logic       ov;
        logic [3:0] f;
        logic       c;
        logic       z;
        logic       n;
        logic [1:0] occ;
        logic       st;
    } vec_t;

    typedef struct {
        logic [3:0] f;
        logic       c;
        int         pos;
    } item_t;

    vec_t  tbl [15];
    item_t q[$];
    logic  m_sticky;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] fin, input logic cin,
                         input logic ordy, input logic fl);
        in_valid    = iv;
        alu_f_in    = fin;
        alu_cout_in = cin;
        out_ready   = ordy;
        flush       = fl;
    endtask

    function automatic logic exp_sticky(input logic s);
`ifdef ALU_OUT_STICKY_CARRY_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    // Model: ordered queue of items, each with a pipeline position; front item exits from position DEPTH-1.
    task automatic model_step(input logic iv, input logic [3:0] fin, input logic cin,
                              input logic ordy, input logic fl, input logic acc);
        item_t t;
        int    lim;
        logic  ov;
        ov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
        if (fl) begin
            q.delete();
            m_sticky = 1'b0;
        end else begin
            if (ov && ordy) begin
                if (q[0].c) m_sticky = 1'b1;
                void'(q.pop_front());
            end
            for (int i = 0; i < q.size(); i++) begin
                lim = (i == 0) ? DEPTH - 1 : q[i-1].pos - 1;
                t = q[i];
                t.pos = (t.pos + 1 > lim) ? lim : t.pos + 1;
                q[i] = t;
            end
            if (iv && acc) begin
                t.f = fin;
                t.c = cin;
                t.pos = 0;
                q.push_back(t);
            end
        end
    endtask

    initial begin
        logic       iv, cin, ordy, fl, eir, eov;
        logic [3:0] fin;
        item_t      hd;

        tbl[0]  = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[1]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        tbl[3]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[4]  = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        tbl[5]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
        tbl[6]  = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
        tbl[7]  = '{1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[10] = '{1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1};
        tbl[12] = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1};
        tbl[13] = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

        reset = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Fill both stages, then hit reset asynchronously mid-cycle.
        @(posedge clk); #1;
        drive(1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("fill_occ", occupancy, 2);
        chk("fill_out_valid", out_valid, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_occ", occupancy, 0);
        chk("async_f", f, 0);
        chk("async_cout", cout, 0);
        chk("async_zero", zero, 0);
        chk("async_neg", neg, 0);
        chk("async_sticky", cout_sticky, 0);
        chk("async_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("deassert_in_ready", in_ready, 1);
        chk("deassert_occ", occupancy, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].iv, tbl[i].fin, tbl[i].cin, tbl[i].ordy, tbl[i].fl);
            #2;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
            chk($sformatf("tbl%0d_sticky", i), cout_sticky, exp_sticky(tbl[i].st));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_f", i), f, tbl[i].f);
                chk($sformatf("tbl%0d_cout", i), cout, tbl[i].c);
                chk($sformatf("tbl%0d_zero", i), zero, tbl[i].z);
                chk($sformatf("tbl%0d_neg", i), neg, tbl[i].n);
            end
        end

        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        m_sticky = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            iv   = ($urandom_range(0, 99) < 60);
            fin  = 4'($urandom);
            cin  = 1'($urandom);
            ordy = ($urandom_range(0, 99) < 55);
            fl   = ($urandom_range(0, 99) < 4);
            drive(iv, fin, cin, ordy, fl);
            #2;
            eir = !fl && ((q.size() < DEPTH) || ordy);
            chk("rnd_in_ready", in_ready, eir);
            model_step(iv, fin, cin, ordy, fl, eir);
            @(posedge clk); #1;
            eov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
            chk("rnd_out_valid", out_valid, eov);
            chk("rnd_occ", occupancy, q.size());
            chk("rnd_sticky", cout_sticky, exp_sticky(m_sticky));
            if (eov) begin
                hd = q[0];
                chk("rnd_f", f, hd.f);
                chk("rnd_cout", cout, hd.c);
                chk("rnd_zero", zero, (hd.f == 4'h0));
                chk("rnd_neg", neg, hd.f[3]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
